// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared constants, FSM state type and register-map helper for the PWM ramp sequencer.
// The address map is common to every pwm_channel unit on IO_bus.
package pwm_ramp_sequencer_pkg;

  localparam logic [7:0] PWM_BASE          = 8'h40;
  localparam int         NOS_PWM_REGISTERS = 4;
  localparam int         PWM_ON_TIME       = 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE,
    ADVANCE
  } ramp_state_t;

  // Bus address of the PWM_ON_TIME register of a given unit.
  function automatic logic [7:0] on_time_addr(input int unsigned unit);
    return PWM_BASE + 8'(unit * NOS_PWM_REGISTERS + PWM_ON_TIME);
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_prescaler.sv
// Ramp tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick for one
// cycle on the wrap; the count is held at zero while disabled.
module pwm_ramp_sequencer_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign tick = enable && wrap;

  // NOTE: every combinational output gets its default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable)   cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only; blocking ones here
  // would make the result depend on process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/slew controller: on each ramp tick, scans channels round-robin and steps
// each channel's T_on toward its target, issuing PWM_ON_TIME writes on a valid/ready port.
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int NOS_CHANNELS = 4,
  parameter int TICK_DIV     = 50000,
  parameter int DATA_W       = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            cfg_we,
  input  logic [$clog2(NOS_CHANNELS)-1:0] cfg_chan,
  input  logic [DATA_W-1:0]               cfg_target,
  input  logic [DATA_W-1:0]               cfg_step,
  output logic                            wr_valid,
  output logic [7:0]                      wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_ready,
  output logic                            busy,
  output logic [NOS_CHANNELS-1:0]         at_target,
  output logic                            overrun
);

  localparam int CHAN_W = $clog2(NOS_CHANNELS);

  ramp_state_t       state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              tick_pending_q, tick_pending_d;
  logic              overrun_q, overrun_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] current_q [NOS_CHANNELS];
  logic [DATA_W-1:0] current_d [NOS_CHANNELS];
  logic [DATA_W-1:0] target_q  [NOS_CHANNELS];
  logic [DATA_W-1:0] target_d  [NOS_CHANNELS];
  logic [DATA_W-1:0] next_val;
  logic              tick;
  logic              go;

  // Distance is taken before the add/sub, so the result never overshoots or wraps.
  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] tgt,
                                                    input logic [DATA_W-1:0] step);
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] res;
    res = cur;
    if (tgt > cur) begin
      diff = tgt - cur;
      res  = cur + ((step < diff) ? step : diff);
    end else if (tgt < cur) begin
      diff = cur - tgt;
      res  = cur - ((step < diff) ? step : diff);
    end
    return res;
  endfunction

  pwm_ramp_sequencer_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_ramp_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign next_val = step_toward(current_q[chan_q], target_q[chan_q], cfg_step);
  assign go       = (state_q == IDLE) && enable && (tick_pending_q || tick);

  always_comb begin
    state_d        = state_q;
    chan_d         = chan_q;
    tick_pending_d = tick_pending_q;
    overrun_d      = overrun_q;
    wr_valid_d     = wr_valid_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    current_d      = current_q;
    target_d       = target_q;

    if (cfg_we) target_d[cfg_chan] = cfg_target;

    // A tick that finds one already waiting is dropped and flagged.
    if (tick && tick_pending_q) overrun_d = 1'b1;
    if (!enable || go) tick_pending_d = 1'b0;
    else if (tick)     tick_pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SCAN;
          chan_d  = '0;
        end
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (next_val != current_q[chan_q]) begin
          state_d    = ISSUE;
          wr_valid_d = 1'b1;
          wr_addr_d  = on_time_addr(32'(chan_q));
          wr_data_d  = next_val;
        end else begin
          state_d = ADVANCE;
        end
      end
      ISSUE: begin
        // Commit the value actually sent, so a target change mid-write cannot leak in.
        if (wr_ready) begin
          current_d[chan_q] = wr_data_q;
          wr_valid_d        = 1'b0;
          state_d           = ADVANCE;
        end
      end
      ADVANCE: begin
        if (!enable || chan_q == CHAN_W'(NOS_CHANNELS - 1)) begin
          state_d = IDLE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the channel arrays are reset too; reset defines every current/target as
  // zero, so they cannot be left as uninitialised storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      chan_q         <= '0;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      current_q      <= '{default: '0};
      target_q       <= '{default: '0};
    end else begin
      state_q        <= state_d;
      chan_q         <= chan_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;
      wr_valid_q     <= wr_valid_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      current_q      <= current_d;
      target_q       <= target_d;
    end
  end

  always_comb begin
    at_target = '0;
    for (int c = 0; c < NOS_CHANNELS; c++) at_target[c] = (current_q[c] == target_q[c]);
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: vector table, directed corner sequences
// and randomized targets/steps/backpressure against a write-sequence model.
module tb_pwm_ramp_sequencer;
  import pwm_ramp_sequencer_pkg::*;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_we = 1'b0;
  logic [1:0]   cfg_chan = '0;
  logic [W-1:0] cfg_target = '0;
  logic [W-1:0] cfg_step = '0;
  logic         wr_ready = 1'b0;
  logic         wr_valid;
  logic [7:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic [N-1:0] at_target;
  logic         overrun;

  pwm_ramp_sequencer #(.NOS_CHANNELS(N), .TICK_DIV(DIV), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_chan(cfg_chan),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .at_target(at_target),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           c;
    logic [W-1:0] tgt;
    logic [W-1:0] step;
    int           n;
    logic [W-1:0] d0, d1, d2;
    logic [N-1:0] at;
  } vec_t;

  int           compared = 0;
  int           mismatched = 0;
  logic [39:0]  exp_q[$];
  logic [W-1:0] mdl_cur [N];
  logic [W-1:0] mdl_tgt [N];
  logic         rdy_rand = 1'b0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_addr;
  logic [W-1:0] prev_data;
  logic [39:0]  mon_e;
  vec_t         vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] addr_of(input int c);
    return 8'(int'(PWM_BASE) + c * NOS_PWM_REGISTERS + PWM_ON_TIME);
  endfunction

  // Move by the signed distance, clamped to +/-step.
  function automatic logic [W-1:0] mdl_step(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                            input logic [W-1:0] step);
    longint gap, lim, mv;
    gap = longint'({32'd0, tgt}) - longint'({32'd0, cur});
    lim = longint'({32'd0, step});
    mv  = gap;
    if (gap > lim)  mv = lim;
    if (gap < -lim) mv = -lim;
    return W'(longint'({32'd0, cur}) + mv);
  endfunction

  task automatic push_write(input int c, input logic [W-1:0] d);
    exp_q.push_back({addr_of(c), d});
    mdl_cur[c] = d;
  endtask

  task automatic cfg_write(input int c, input logic [W-1:0] t);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_chan = 2'(c); cfg_target = t;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl_tgt[c] = t;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; cfg_we = 1'b0; rdy_rand = 1'b0; wr_ready = 1'b0;
    exp_q.delete();
    for (int c = 0; c < N; c++) begin mdl_cur[c] = '0; mdl_tgt[c] = '0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_at_target"}, at_target, 4'hF);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin @(negedge clk); cyc++; end
    check({tag, "_writes_left"}, exp_q.size(), 0);
  endtask

  // Write monitor: every accepted write must be the next one the model expects,
  // and a stalled write must hold its address and data.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {wr_valid, wr_addr, wr_data}, {1'b1, prev_addr, prev_data});
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {wr_addr, wr_data}, mon_e);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) wr_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic moved;
    logic [N-1:0] mdl_at;
    logic [W-1:0] nxt;

    vecs[0] = '{0, 32'd10,         32'd4,         3, 32'd4,         32'd8,         32'd10, 4'hF};
    vecs[1] = '{1, 32'd10,         32'd10,        1, 32'd10,        32'd0,         32'd0,  4'hF};
    vecs[2] = '{1, 32'd3,          32'd5,         2, 32'd5,         32'd3,         32'd0,  4'hF};
    vecs[3] = '{2, 32'hFFFF_FFE0,  32'hFFFF_FFFF, 1, 32'hFFFF_FFE0, 32'd0,         32'd0,  4'hF};
    vecs[4] = '{2, 32'hFFFF_FFF0,  32'h100,       1, 32'hFFFF_FFF0, 32'd0,         32'd0,  4'hF};
    vecs[5] = '{3, 32'd7,          32'd0,         0, 32'd0,         32'd0,         32'd0,  4'h7};
    vecs[6] = '{3, 32'd7,          32'd3,         3, 32'd3,         32'd6,         32'd7,  4'hF};
    vecs[7] = '{0, 32'd0,          32'd6,         2, 32'd4,         32'd0,         32'd0,  4'hF};
    vecs[8] = '{2, 32'hFFFF_FFFF,  32'd8,         2, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0,  4'hF};

    #1;
    check_reset_values("reset_state");
    do_reset();
    check_reset_values("after_reset");

    // Vector table: one target change at a time, always-ready write port.
    wr_ready = 1'b1;
    enable   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cfg_step = vecs[i].step;
      if (vecs[i].n > 0) push_write(vecs[i].c, vecs[i].d0);
      if (vecs[i].n > 1) push_write(vecs[i].c, vecs[i].d1);
      if (vecs[i].n > 2) push_write(vecs[i].c, vecs[i].d2);
      cfg_write(vecs[i].c, vecs[i].tgt);
      drain($sformatf("vec%0d", i), 300);
      repeat (24) @(negedge clk);
      check($sformatf("vec%0d_extra", i), exp_q.size(), 0);
      check($sformatf("vec%0d_at_target", i), at_target, vecs[i].at);
    end

    // Randomized targets/steps with random backpressure.
    for (int r = 0; r < 6; r++) begin
      enable = 1'b0;
      cyc = 0;
      while (busy && cyc < 60) begin @(negedge clk); cyc++; end
      check($sformatf("rnd%0d_halt_busy", r), busy, 0);
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 3))
          0:       cfg_write(c, '0);
          1:       cfg_write(c, '1);
          default: cfg_write(c, $urandom);
        endcase
      end
      cfg_step = ($urandom_range(0, 5) == 0) ? '0 : ($urandom | 32'h1000_0000);
      do begin
        moved = 1'b0;
        for (int c = 0; c < N; c++) begin
          nxt = mdl_step(mdl_cur[c], mdl_tgt[c], cfg_step);
          if (nxt != mdl_cur[c]) begin push_write(c, nxt); moved = 1'b1; end
        end
      end while (moved);
      for (int c = 0; c < N; c++) mdl_at[c] = (mdl_cur[c] == mdl_tgt[c]);
      rdy_rand = 1'b1;
      enable   = 1'b1;
      drain($sformatf("rnd%0d", r), 6000);
      repeat (30) @(negedge clk);
      check($sformatf("rnd%0d_at_target", r), at_target, mdl_at);
      rdy_rand = 1'b0;
      wr_ready = 1'b1;
    end

    // Stalled write: stable outputs, pending then overrun, target change in flight.
    do_reset();
    cfg_step = 32'd4;
    cfg_write(0, 32'd100);
    push_write(0, 32'd4);
    enable = 1'b1;
    cyc = 0;
    while (!wr_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("stall_first_valid", wr_valid, 1);
    check("stall_first_addr", wr_addr, addr_of(0));
    check("stall_first_data", wr_data, 4);
    check("stall_overrun_early", overrun, 0);
    repeat (5) @(negedge clk);
    check("stall_overrun_after_2nd_tick", overrun, 0);
    cfg_write(0, 32'd4);
    repeat (12) @(negedge clk);
    check("stall_overrun_after_3rd_tick", overrun, 1);
    check("stall_valid_held", wr_valid, 1);
    check("stall_inflight_data", wr_data, 4);
    wr_ready = 1'b1;
    drain("stall_release", 10);
    repeat (24) @(negedge clk);
    check("stall_at_target", at_target, 4'hF);
    check("stall_overrun_sticky", overrun, 1);

    // All four channels off target: one scan writes units 0..3 in order.
    do_reset();
    wr_ready = 1'b1;
    cfg_step = '1;
    cfg_write(0, 32'd9);
    cfg_write(1, 32'd20);
    cfg_write(2, 32'd30);
    cfg_write(3, 32'd40);
    for (int c = 0; c < N; c++) push_write(c, mdl_tgt[c]);
    enable = 1'b1;
    drain("scan4", 100);
    check("scan4_busy_during", busy, 1);
    cyc = 0;
    while (busy && cyc < 16) begin @(negedge clk); cyc++; end
    check("scan4_busy_falls", busy, 0);
    check("scan4_at_target", at_target, 4'hF);

    // Reset while a write is outstanding.
    do_reset();
    cfg_step = '1;
    cfg_write(1, 32'd55);
    enable = 1'b1;
    cyc = 0;
    while (!wr_valid && cyc < 30) begin @(negedge clk); cyc++; end
    check("rst_issue_valid", wr_valid, 1);
    check("rst_issue_addr", wr_addr, addr_of(1));
    check("rst_issue_data", wr_data, 55);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("rst_in_issue");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_post_valid", wr_valid, 0);
    check("rst_post_at_target", at_target, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
